// File: rtl/gpio_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpio_mmio_pkg
// Brief    : Shared register offsets and bus FSM state type for the GPIO
//            memory-mapped responder.
// Revision : 1.0 - initial release
// ============================================================================
package gpio_mmio_pkg;

    // Byte offsets of the four 32-bit registers; only bits [3:2] decode.
    localparam logic [3:0] GPIO_DATA_OUT  = 4'h0;
    localparam logic [3:0] GPIO_DATA_IN   = 4'h4;
    localparam logic [3:0] GPIO_EDGE_STAT = 4'h8;
    localparam logic [3:0] GPIO_EDGE_EN   = 4'hC;

    // Bus handshake: accept in IDLE, pulse ready for one cycle in RESP.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } bus_state_t;

endpackage
`default_nettype wire

// File: rtl/gpio_in_sync.sv
`default_nettype none
// ============================================================================
// Module   : gpio_in_sync
// Brief    : Two-flop synchronizer for asynchronous GPIO inputs, followed by
//            a history register used to detect rising edges.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_in_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_prev;

    // Metastability filter plus one cycle of history for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/gpio_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : gpio_mmio_responder
// Brief    : Memory-mapped GPIO peripheral on the core data bus. Provides an
//            output register, a synchronized input view, sticky rising-edge
//            flags (write-1-to-clear) and a maskable registered interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_mmio_responder
    import gpio_mmio_pkg::*;
#(
    parameter int GPIO_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bus_req,
    input  logic                  bus_we,
    input  logic [3:0]            bus_addr,
    input  logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  bus_ready,
    input  logic [GPIO_WIDTH-1:0] GPIO_In,
    output logic [GPIO_WIDTH-1:0] GPIO_Out,
    output logic                  irq
);

    localparam logic [1:0] c_idx_out  = GPIO_DATA_OUT[3:2];
    localparam logic [1:0] c_idx_in   = GPIO_DATA_IN[3:2];
    localparam logic [1:0] c_idx_stat = GPIO_EDGE_STAT[3:2];
    localparam logic [1:0] c_idx_en   = GPIO_EDGE_EN[3:2];

    bus_state_t            r_state;
    bus_state_t            w_next_state;
    logic                  w_accept;

    logic [GPIO_WIDTH-1:0] r_data_out;
    logic [GPIO_WIDTH-1:0] r_edge_stat;
    logic [GPIO_WIDTH-1:0] r_edge_en;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_irq;

    logic [GPIO_WIDTH-1:0] w_sync;
    logic [GPIO_WIDTH-1:0] w_rise;
    logic [1:0]            w_sel;
    logic [GPIO_WIDTH-1:0] w_wdata;
    logic                  w_wr_out;
    logic                  w_wr_en;
    logic [GPIO_WIDTH-1:0] w_clr;
    logic [DATA_WIDTH-1:0] w_rd_mux;

    // Upper write-data bits and the byte-lane address bits carry no meaning.
    logic                  w_unused;
    assign w_unused = ^{bus_wdata, bus_addr};

    gpio_in_sync #(
        .WIDTH (GPIO_WIDTH)
    ) u_in_sync (
        .clk     (clk),
        .rst     (reset),
        .i_async (GPIO_In),
        .o_sync  (w_sync),
        .o_rise  (w_rise)
    );

    assign w_sel    = bus_addr[3:2];
    assign w_wdata  = bus_wdata[GPIO_WIDTH-1:0];
    assign w_wr_out = w_accept && bus_we && (w_sel == c_idx_out);
    assign w_wr_en  = w_accept && bus_we && (w_sel == c_idx_en);
    assign w_clr    = (w_accept && bus_we && (w_sel == c_idx_stat)) ? w_wdata : '0;

    // Bus FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Bus FSM next state: requests are only looked at while idle.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus_req) begin
                    w_accept     = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Read multiplexer, zero-extended to the bus width.
    always_comb begin
        w_rd_mux = '0;
        case (w_sel)
            c_idx_out:  w_rd_mux[GPIO_WIDTH-1:0] = r_data_out;
            c_idx_in:   w_rd_mux[GPIO_WIDTH-1:0] = w_sync;
            c_idx_stat: w_rd_mux[GPIO_WIDTH-1:0] = r_edge_stat;
            c_idx_en:   w_rd_mux[GPIO_WIDTH-1:0] = r_edge_en;
            default:    w_rd_mux = '0;
        endcase
    end

    // Register file; a new edge in the clear cycle keeps its flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_out  <= '0;
            r_edge_en   <= '0;
            r_edge_stat <= '0;
        end else begin
            if (w_wr_out) begin
                r_data_out <= w_wdata;
            end
            if (w_wr_en) begin
                r_edge_en <= w_wdata;
            end
            r_edge_stat <= (r_edge_stat & ~w_clr) | w_rise;
        end
    end

    // Read data captured at the accept edge; writes return zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_accept) begin
            r_rdata <= bus_we ? '0 : w_rd_mux;
        end
    end

    // Interrupt registered from the current flags and mask.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_edge_stat & r_edge_en);
        end
    end

    assign bus_ready = (r_state == RESP);
    assign bus_rdata = bus_ready ? r_rdata : '0;
    assign GPIO_Out  = r_data_out;
    assign irq       = r_irq;

endmodule
`default_nettype wire
